if_fetch_buffer: RTL and testbench

- Fetch-side decoupling buffer that sits directly downstream of the PC register and upstream of the decode stage in the pipelined MIPS core.
- Captures each {PC, instruction} pair produced in the F stage into a small circular FIFO and presents the oldest entry to D with valid/stall handshaking.
- Drives the PC register's enable (f_ready), so the PC advances only when the buffer can accept an entry.
- Checks every fetch address for an instruction-fetch address error and tags the entry.

---
 rtl/if_fetch_buffer_pkg.sv | 26 ++
 rtl/if_fetch_fifo_mem.sv | 28 ++
 rtl/if_fetch_buffer.sv | 104 ++++++++++
 tb/tb_if_fetch_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-side definitions: legal instruction window, NOP encoding and
// the buffered fetch-entry layout used by the PC register and fetch buffer.
package if_fetch_buffer_pkg;

    localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT_DEFAULT = 32'h0000_6FFC;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    localparam int ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    // Address error: misaligned, or outside the instruction memory window.
    function automatic logic fetch_adel(
        input logic [31:0] pc,
        input logic [31:0] base,
        input logic [31:0] limit
    );
        return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
    endfunction

endpackage

// File: rtl/if_fetch_fifo_mem.sv
// Fetch-buffer storage: DEPTH entries, one write port, one combinational read
// port. Contents are not reset; the pointers in the parent qualify them.
module if_fetch_fifo_mem
    import if_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  fetch_entry_t wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output fetch_entry_t rd_data
);

    fetch_entry_t entry_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_reg[wr_addr] <= wr_data;
        end
    end

    // Read is combinational so the head is visible one cycle after its push.
    assign rd_data = entry_reg[rd_addr];

endmodule

// File: rtl/if_fetch_buffer.sv
// F->D decoupling buffer: captures {PC, instruction, adel} into a small
// circular FIFO, drives the PC enable and presents the oldest entry to decode.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                f_pc,
    input  logic [31:0]                f_instr,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic                       flush,
    input  logic                       d_stall,
    output logic                       d_valid,
    output logic [31:0]                d_pc,
    output logic [31:0]                d_instr,
    output logic                       d_exc_adel,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;

    logic         push;
    logic         pop;
    logic         wr_adel;
    fetch_entry_t wr_entry;
    fetch_entry_t head_entry;

    // Handshake depends on registered occupancy only.
    assign f_ready = (count_reg != FULL_COUNT);
    assign d_valid = (count_reg != '0);
    assign push    = f_valid & f_ready & ~flush;
    assign pop     = d_valid & ~d_stall & ~flush;

    assign wr_adel        = fetch_adel(f_pc, IM_BASE, IM_LIMIT);
    assign wr_entry.pc    = f_pc;
    assign wr_entry.instr = wr_adel ? NOP_INSTR : f_instr;
    assign wr_entry.adel  = wr_adel;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    if_fetch_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_entry)
    );

    // An empty buffer presents all-zero head fields.
    assign d_pc       = d_valid ? head_entry.pc    : 32'h0;
    assign d_instr    = d_valid ? head_entry.instr : 32'h0;
    assign d_exc_adel = d_valid & head_entry.adel;
    assign count      = count_reg;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer: directed vector table, a pointer
// wrap sequence, and randomized traffic against a queue-based reference.
module tb_if_fetch_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_ready;
    logic        flush;
    logic        d_stall;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_exc_adel;
    logic [1:0]  count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .f_valid    (f_valid),
        .f_ready    (f_ready),
        .flush      (flush),
        .d_stall    (d_stall),
        .d_valid    (d_valid),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_exc_adel (d_exc_adel),
        .count      (count)
    );

    // Reference model: a plain queue of what decode should eventually see.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ref_entry_t;

    ref_entry_t model_q[$];

    function automatic logic ref_adel(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fl;
        logic        st;
        logic        rs;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_adel;
        logic [1:0]  e_count;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic fv, input logic [31:0] pc, input logic [31:0] instr,
        input logic fl, input logic st, input logic rs,
        input logic ev, input logic [31:0] epc, input logic [31:0] ei,
        input logic ea, input logic [1:0] ec, input logic er
    );
        vec_t v;
        v.fv = fv; v.pc = pc; v.instr = instr; v.fl = fl; v.st = st; v.rs = rs;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ei; v.e_adel = ea;
        v.e_count = ec; v.e_ready = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then wait
    // for the falling edge where outputs are sampled.
    task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic fl, input logic st, input logic rs);
        logic do_push, do_pop;
        ref_entry_t e;
        f_valid = fv; f_pc = pc; f_instr = instr;
        flush = fl; d_stall = st; reset = rs;
        do_push = fv && (model_q.size() != DEPTH) && !fl;
        do_pop  = (model_q.size() != 0) && !st && !fl;
        @(posedge clk);
        if (rs || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc    = pc;
                e.adel  = ref_adel(pc);
                e.instr = e.adel ? 32'h0 : instr;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        int n;
        n = model_q.size();
        chk({tag, " count"},   32'(count),      32'(n));
        chk({tag, " f_ready"}, 32'(f_ready),    32'(n != DEPTH));
        chk({tag, " d_valid"}, 32'(d_valid),    32'(n != 0));
        chk({tag, " d_pc"},    d_pc,            (n != 0) ? model_q[0].pc : 32'h0);
        chk({tag, " d_instr"}, d_instr,         (n != 0) ? model_q[0].instr : 32'h0);
        chk({tag, " d_adel"},  32'(d_exc_adel), (n != 0) ? 32'(model_q[0].adel) : 32'h0);
    endtask

    initial begin
        vec_t v;
        string tag;
        int   k, guard;
        logic [31:0] pc_next;
        logic        st;

        reset = 1'b1; f_valid = 1'b0; f_pc = 32'h0; f_instr = 32'h0;
        flush = 1'b0; d_stall = 1'b0;
        @(negedge clk);
        cycle(1'b1, 32'h3000, 32'h1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        compare_model("reset");
        chk("reset d_pc_zero", d_pc, 32'h0);
        chk("reset f_ready_one", 32'(f_ready), 32'h1);

        //   fv  pc            instr         fl  st  rs | valid pc  instr  adel cnt rdy
        // steady flow
        add(1, 32'h3000, 32'h24010001, 0, 0, 0,  1, 32'h3000, 32'h24010001, 0, 1, 1);
        add(1, 32'h3004, 32'h24020002, 0, 0, 0,  1, 32'h3004, 32'h24020002, 0, 1, 1);
        add(1, 32'h3008, 32'h24030003, 0, 0, 0,  1, 32'h3008, 32'h24030003, 0, 1, 1);
        add(0, 32'h0,    32'h0,        0, 0, 0,  0, 32'h0,    32'h0,        0, 0, 1);
        // stall until full, then drain without loss or duplication
        add(1, 32'h3000, 32'h11, 0, 1, 0,  1, 32'h3000, 32'h11, 0, 1, 1);
        add(1, 32'h3004, 32'h12, 0, 1, 0,  1, 32'h3000, 32'h11, 0, 2, 0);
        add(1, 32'h3008, 32'h13, 0, 1, 0,  1, 32'h3000, 32'h11, 0, 2, 0);
        add(1, 32'h3008, 32'h13, 0, 0, 0,  1, 32'h3004, 32'h12, 0, 1, 1);
        add(1, 32'h3008, 32'h13, 0, 0, 0,  1, 32'h3008, 32'h13, 0, 1, 1);
        add(0, 32'h0,    32'h0,  0, 0, 0,  0, 32'h0,    32'h0,  0, 0, 1);
        // flush while full drops the presented entry
        add(1, 32'h3000, 32'h21, 0, 1, 0,  1, 32'h3000, 32'h21, 0, 1, 1);
        add(1, 32'h3004, 32'h22, 0, 1, 0,  1, 32'h3000, 32'h21, 0, 2, 0);
        add(1, 32'h3010, 32'h23, 1, 1, 0,  0, 32'h0,    32'h0,  0, 0, 1);
        add(1, 32'h3040, 32'h24, 0, 1, 0,  1, 32'h3040, 32'h24, 0, 1, 1);
        add(0, 32'h0,    32'h0,  0, 0, 0,  0, 32'h0,    32'h0,  0, 0, 1);
        // fetch address errors
        add(1, 32'h3002, 32'hDEADBEEF, 0, 0, 0,  1, 32'h3002, 32'h0,    1, 1, 1);
        add(1, 32'h2FFC, 32'hDEADBEEF, 0, 0, 0,  1, 32'h2FFC, 32'h0,    1, 1, 1);
        add(1, 32'h7000, 32'hDEADBEEF, 0, 0, 0,  1, 32'h7000, 32'h0,    1, 1, 1);
        add(1, 32'h6FFC, 32'h00001234, 0, 0, 0,  1, 32'h6FFC, 32'h1234, 0, 1, 1);
        // reset mid-stream while stalled
        add(0, 32'h0,    32'h0,  0, 1, 0,  1, 32'h6FFC, 32'h1234, 0, 1, 1);
        add(1, 32'h3000, 32'h55, 0, 1, 1,  0, 32'h0,    32'h0,    0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(v.fv, v.pc, v.instr, v.fl, v.st, v.rs);
            tag = $sformatf("vec%0d", i);
            chk({tag, " d_valid"}, 32'(d_valid),    32'(v.e_valid));
            chk({tag, " d_pc"},    d_pc,            v.e_pc);
            chk({tag, " d_instr"}, d_instr,         v.e_instr);
            chk({tag, " d_adel"},  32'(d_exc_adel), 32'(v.e_adel));
            chk({tag, " count"},   32'(count),      32'(v.e_count));
            chk({tag, " f_ready"}, 32'(f_ready),    32'(v.e_ready));
        end

        // Pointer wrap: sequential PCs under random stall must pop in order.
        pc_next = 32'h3000;
        k = 0;
        guard = 0;
        while (k < 6 && guard < 200) begin
            st = ($urandom_range(0, 1) == 0);
            if (d_valid && !st) begin
                chk($sformatf("wrap pop%0d d_pc", k), d_pc, 32'h3000 + 32'(4 * k));
                k++;
            end
            if (f_ready && pc_next < 32'h3000 + 32'd24) begin
                cycle(1'b1, pc_next, pc_next ^ 32'hA5A5_0000, 1'b0, st, 1'b0);
                pc_next = pc_next + 32'd4;
            end else begin
                cycle(1'b0, 32'h0, 32'h0, 1'b0, st, 1'b0);
            end
            guard++;
        end
        if (k < 6) begin
            checks++;
            failures++;
            $display("FAIL wrap_timeout actual=%0d pops required=6", k);
        end
        compare_model("wrap_end");

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            case ($urandom_range(0, 5))
                0:       rpc = 32'h2FFC;
                1:       rpc = 32'h7000;
                2:       rpc = 32'h3000 + 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 1000)) * 4;
                3:       rpc = $urandom;
                default: rpc = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            endcase
            cycle($urandom_range(0, 3) != 0, rpc, $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 49) == 0);
            compare_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
